vga_text_fetch: RTL and testbench

VGA_TEXT_FETCH -- requirements
Module: vga_text_fetch

---
 rtl/vga_text_fetch.sv | 122 ++++++++++++
 tb/tb_vga_text_fetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_text_fetch.sv
// Text-mode pixel fetch: character RAM -> font ROM -> RGB332 with aligned syncs, latency 4 clocks.
// Optional blinking underline cursor compiled in with VGA_TEXT_CURSOR_EN.
module vga_text_fetch #(
    parameter logic [7:0] FG_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR = 8'h00,
    parameter int         COLS     = 50
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [8:0]  pix,
    input  logic [8:0]  line,
    input  logic        visible,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    output logic [10:0] vram_addr,
    input  logic [7:0]  vram_rdata,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_rdata,
    output logic [7:0]  rgb,
    output logic        h_sync,
    output logic        v_sync
`ifdef VGA_TEXT_CURSOR_EN
    ,
    input  logic [5:0]  cursor_col,
    input  logic [5:0]  cursor_row,
    input  logic        cursor_on
`endif
);

    localparam logic [10:0] COLS_W = 11'(COLS);
`ifdef VGA_TEXT_CURSOR_EN
    localparam int GROW_DEPTH = 4;
`else
    localparam int GROW_DEPTH = 2;
`endif

    // Index 0 is the newest stage; the top index carries data sampled 4 (or 2) edges ago.
    logic [3:0][2:0]            bit_sel_d;
    logic [GROW_DEPTH-1:0][2:0] grow_d;
    logic [3:0]                 vis_d;
    logic [3:0]                 hs_d;
    logic [3:0]                 vs_d;

    logic [10:0] vram_addr_s;
    logic [7:0]  rgb_s;
    logic        bit_on_s;
    logic        cursor_hit_s;

`ifdef VGA_TEXT_CURSOR_EN
    logic [3:0][5:0] col_d;
    logic [3:0][5:0] row_d;
    logic [4:0]      frame_cnt;
    logic            vs_in_prev;

    // Frame counter advances on each rising edge of the incoming vertical sync.
    always_ff @(negedge clk) begin
        if (!n_reset) begin
            frame_cnt  <= 5'd0;
            vs_in_prev <= 1'b0;
            col_d      <= '0;
            row_d      <= '0;
        end else begin
            vs_in_prev <= v_sync_in;
            if (v_sync_in && !vs_in_prev) begin
                frame_cnt <= frame_cnt + 5'd1;
            end else begin
                frame_cnt <= frame_cnt;
            end
            col_d <= {col_d[2:0], pix[8:3]};
            row_d <= {row_d[2:0], line[8:3]};
        end
    end
`endif

    // Character address and pixel colour selection.
    always_comb begin
        vram_addr_s = {5'd0, line[8:3]} * COLS_W + {5'd0, pix[8:3]};
        bit_on_s    = font_rdata[3'd7 - bit_sel_d[3]];
`ifdef VGA_TEXT_CURSOR_EN
        cursor_hit_s = cursor_on && frame_cnt[4] &&
                       (col_d[3] == cursor_col) && (row_d[3] == cursor_row) &&
                       (grow_d[3][2:1] == 2'b11);
`else
        cursor_hit_s = 1'b0;
`endif
        if (!vis_d[3]) begin
            rgb_s = 8'h00;
        end else if (bit_on_s || cursor_hit_s) begin
            rgb_s = FG_COLOR;
        end else begin
            rgb_s = BG_COLOR;
        end
    end

    // Fetch pipeline: addresses every edge, side-band shifted so rgb and syncs stay aligned.
    always_ff @(negedge clk) begin
        if (!n_reset) begin
            vram_addr <= 11'd0;
            font_addr <= 11'd0;
            rgb       <= 8'h00;
            h_sync    <= 1'b0;
            v_sync    <= 1'b0;
            bit_sel_d <= '0;
            grow_d    <= '0;
            vis_d     <= 4'd0;
            hs_d      <= 4'd0;
            vs_d      <= 4'd0;
        end else begin
            vram_addr <= vram_addr_s;
            font_addr <= {vram_rdata, grow_d[1]};
            rgb       <= rgb_s;
            h_sync    <= hs_d[3];
            v_sync    <= vs_d[3];
            bit_sel_d <= {bit_sel_d[2:0], pix[2:0]};
            grow_d    <= {grow_d[GROW_DEPTH-2:0], line[2:0]};
            vis_d     <= {vis_d[2:0], visible};
            hs_d      <= {hs_d[2:0], h_sync_in};
            vs_d      <= {vs_d[2:0], v_sync_in};
        end
    end

endmodule

// File: tb/tb_vga_text_fetch.sv
// Directed self-checking bench for vga_text_fetch with simple synchronous-read memory models.
module tb_vga_text_fetch;

    localparam logic [7:0] FG = 8'hE3;
    localparam logic [7:0] BG = 8'h1C;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [8:0]  pix;
    logic [8:0]  line;
    logic        visible;
    logic        h_sync_in;
    logic        v_sync_in;
    logic [10:0] vram_addr;
    logic [7:0]  vram_rdata = 8'h00;
    logic [10:0] font_addr;
    logic [7:0]  font_rdata = 8'h00;
    logic [7:0]  rgb;
    logic        h_sync;
    logic        v_sync;
    logic [7:0]  font_fill;
`ifdef VGA_TEXT_CURSOR_EN
    logic [5:0]  cursor_col = 6'd2;
    logic [5:0]  cursor_row = 6'd1;
    logic        cursor_on  = 1'b1;
`endif

    int checks = 0;
    int fails  = 0;

    vga_text_fetch #(.FG_COLOR(FG), .BG_COLOR(BG), .COLS(50)) dut (
        .clk(clk), .n_reset(n_reset), .pix(pix), .line(line), .visible(visible),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .vram_addr(vram_addr), .vram_rdata(vram_rdata),
        .font_addr(font_addr), .font_rdata(font_rdata),
        .rgb(rgb), .h_sync(h_sync), .v_sync(v_sync)
`ifdef VGA_TEXT_CURSOR_EN
        , .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_on(cursor_on)
`endif
    );

    always #25 clk = ~clk;

    // One-cycle synchronous-read memories on the design's active edge; font returns a fixed pattern.
    always @(negedge clk) begin
        vram_rdata <= vram_addr[7:0] ^ 8'h41;
        font_rdata <= font_fill;
    end

    task automatic edge_n(input int n);
        repeat (n) begin
            @(negedge clk);
            @(posedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"}, 32'(rgb), 32'h0);
        check({tag, "_hs"}, 32'(h_sync), 32'h0);
        check({tag, "_vs"}, 32'(v_sync), 32'h0);
        check({tag, "_vaddr"}, 32'(vram_addr), 32'h0);
        check({tag, "_faddr"}, 32'(font_addr), 32'h0);
    endtask

    logic [7:0] sweep_exp [8] = '{FG, BG, FG, BG, BG, FG, BG, FG};

    initial begin
        n_reset = 1'b0; pix = 9'd0; line = 9'd0; visible = 1'b0;
        h_sync_in = 1'b0; v_sync_in = 1'b0; font_fill = 8'h00;
        @(posedge clk);
        edge_n(3);
        check_all_zero("reset");

        // First fetch: cell 0 holds 8'h41, glyph row top bit set.
        n_reset = 1'b1; visible = 1'b1; font_fill = 8'h80;
        edge_n(1);
        check("first_vaddr", 32'(vram_addr), 32'd0);
        check("first_rgb_e0", 32'(rgb), 32'h0);
        edge_n(2);
        check("first_faddr", 32'(font_addr), 32'h208);
        edge_n(1);
        check("first_rgb_e3", 32'(rgb), 32'h0);
        edge_n(1);
        check("first_rgb_e4", 32'(rgb), 32'(FG));

        pix = 9'd399; line = 9'd299;
        edge_n(1);
        check("vaddr_max", 32'(vram_addr), 32'd1899);
        pix = 9'd8; line = 9'd8;
        edge_n(1);
        check("vaddr_51", 32'(vram_addr), 32'd51);
        pix = 9'd16; line = 9'd13;
        edge_n(3);
        check("faddr_row5", 32'(font_addr), 32'h3AD);

        // Bit selection across one glyph row, pattern 1010_0101.
        font_fill = 8'hA5; line = 9'd0;
        for (int i = 0; i < 12; i++) begin
            pix = 9'(i);
            edge_n(1);
            if (i >= 4) check($sformatf("bitsel_%0d", i - 4), 32'(rgb), 32'(sweep_exp[(i - 4) % 8]));
        end

        // Horizontal blanking with sync pulses; blank area must stay black despite full glyph.
        font_fill = 8'hFF;
        for (int p = 396; p <= 500; p++) begin
            pix = 9'(p);
            visible = (p < 400);
            h_sync_in = (p >= 428) && (p <= 491);
            v_sync_in = (p >= 440) && (p <= 447);
            edge_n(1);
            if (p >= 400) begin
                check($sformatf("hs_%0d", p), 32'(h_sync), 32'((p - 4 >= 428) && (p - 4 <= 491)));
                check($sformatf("vs_%0d", p), 32'(v_sync), 32'((p - 4 >= 440) && (p - 4 <= 447)));
                check($sformatf("rgb_%0d", p), 32'(rgb), (p - 4 < 400) ? 32'(FG) : 32'h0);
            end
        end

        // One-clock reset in the middle of a line.
        pix = 9'd100; line = 9'd20; visible = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0;
        edge_n(5);
        check("pre_rst_rgb", 32'(rgb), 32'(FG));
        n_reset = 1'b0;
        edge_n(1);
        check_all_zero("midrst");
        n_reset = 1'b1;
        edge_n(4);
        check("post_rst_rgb_e3", 32'(rgb), 32'h0);
        edge_n(1);
        check("post_rst_rgb_e4", 32'(rgb), 32'(FG));

`ifdef VGA_TEXT_CURSOR_EN
        font_fill = 8'h00;
        repeat (16) begin
            v_sync_in = 1'b1; edge_n(1);
            v_sync_in = 1'b0; edge_n(1);
        end
        pix = 9'd16; line = 9'd14;
        edge_n(5);
        check("cursor_on_l14", 32'(rgb), 32'(FG));
        line = 9'd13;
        edge_n(5);
        check("cursor_off_l13", 32'(rgb), 32'(BG));
        repeat (16) begin
            v_sync_in = 1'b1; edge_n(1);
            v_sync_in = 1'b0; edge_n(1);
        end
        line = 9'd14;
        edge_n(5);
        check("cursor_blink_off", 32'(rgb), 32'(BG));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
